// File: rtl/mem_ctrl_pkg.sv
// Shared request types, operation encodings and DDR5 address field positions.
package mem_ctrl_pkg;
    localparam int NUM_CORES = 12;
    localparam int CORE_W    = 4;
    localparam int ADDR_W    = 36;

    typedef enum logic [1:0] {
        OP_RD     = 2'd0,
        OP_WR     = 2'd1,
        OP_IFETCH = 2'd2
    } op_e;

    localparam int CH_BIT   = 6;
    localparam int BG_LSB   = 7;
    localparam int BG_MSB   = 9;
    localparam int BANK_LSB = 10;
    localparam int BANK_MSB = 11;
    localparam int COL_LSB  = 12;
    localparam int COL_MSB  = 17;
    localparam int ROW_LSB  = 18;
    localparam int ROW_MSB  = 33;

    typedef struct packed {
        op_e               op;
        logic [CORE_W-1:0] core;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;

    localparam int REQ_W = $bits(mem_req_t);

    // Encoding 3 is not an operation; cores above NUM_CORES-1 do not exist.
    function automatic logic req_is_legal(input logic [1:0] op, input logic [CORE_W-1:0] core);
        return (int'(core) < NUM_CORES) && (op != 2'd3);
    endfunction
endpackage

// File: rtl/timing_parameters.sv
// Timing-related defaults shared by the request intake path.
package timing_parameters;
    localparam int TIME_W_DEFAULT = 64;
endpackage

// File: rtl/mem_req_fifo.sv
// Generic circular FIFO: naturally wrapping head/tail pointers plus an occupancy count.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // The head is never forwarded from the write port, so an empty FIFO reads as zero.
    assign rdata = empty ? '0 : mem_q[head_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= wdata;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mem_req_queue.sv
// Trace request intake: time-gated staging FSM feeding a FIFO with decoded DDR5 head fields.
// Optional statistics ports are built when MEM_REQ_STATS_EN is defined.
module mem_req_queue
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TIME_W = timing_parameters::TIME_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TIME_W-1:0]      in_time,
    input  logic [3:0]             in_core,
    input  logic [1:0]             in_op,
    input  logic [35:0]            in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_op,
    output logic [3:0]             out_core,
    output logic [35:0]            out_addr,
    output logic                   out_channel,
    output logic [2:0]             out_bg,
    output logic [1:0]             out_bank,
    output logic [5:0]             out_col,
    output logic [15:0]            out_row,
    output logic [TIME_W-1:0]      now_t,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   err_bounds
`ifdef MEM_REQ_STATS_EN
    ,
    output logic [31:0]            stat_accepted,
    output logic [31:0]            stat_dropped,
    output logic [31:0]            stat_full_cycles,
    output logic [$clog2(DEPTH):0] stat_max_count
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_TIME  = 2'd1,
        S_WAIT_SPACE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] now_q;
    logic [TIME_W-1:0] stage_time_q, stage_time_d;
    mem_req_t          stage_req_q, stage_req_d;
    logic              err_q, err_d;
    logic              req_legal, time_ok, can_push, push, pop;
    logic [REQ_W-1:0]  head_bits;
    mem_req_t          head_req;

    assign req_legal = req_is_legal(in_op, in_core);
    assign time_ok   = (now_q >= stage_time_q);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign can_push  = !full || pop;

    always_comb begin
        state_d      = state_q;
        stage_time_d = stage_time_q;
        stage_req_d  = stage_req_q;
        err_d        = err_q;
        push         = 1'b0;
        in_ready     = (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (req_legal) begin
                        stage_time_d = in_time;
                        stage_req_d  = '{op: op_e'(in_op), core: in_core, addr: in_addr};
                        state_d      = S_WAIT_TIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Falls straight through the space check so a due request pushes this cycle.
            S_WAIT_TIME: begin
                if (time_ok) begin
                    if (can_push) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (can_push) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            now_q        <= '0;
            stage_time_q <= '0;
            stage_req_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            now_q        <= now_q + TIME_W'(1);
            stage_time_q <= stage_time_d;
            stage_req_q  <= stage_req_d;
            err_q        <= err_d;
        end
    end

    mem_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (stage_req_q),
        .rdata (head_bits),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head_req    = mem_req_t'(head_bits);
    assign out_op      = head_req.op;
    assign out_core    = head_req.core;
    assign out_addr    = head_req.addr;
    assign out_channel = head_req.addr[CH_BIT];
    assign out_bg      = head_req.addr[BG_MSB:BG_LSB];
    assign out_bank    = head_req.addr[BANK_MSB:BANK_LSB];
    assign out_col     = head_req.addr[COL_MSB:COL_LSB];
    assign out_row     = head_req.addr[ROW_MSB:ROW_LSB];
    assign now_t       = now_q;
    assign err_bounds  = err_q;

`ifdef MEM_REQ_STATS_EN
    logic [31:0]      stat_acc_q, stat_drop_q, stat_full_q;
    logic [CNT_W-1:0] stat_max_q;
    logic             offer_idle, full_wait;

    assign offer_idle = (state_q == S_IDLE) && in_valid;
    // Staging holds a due request that the full FIFO cannot take.
    assign full_wait  = full && ((state_q == S_WAIT_SPACE) || ((state_q == S_WAIT_TIME) && time_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_acc_q  <= '0;
            stat_drop_q <= '0;
            stat_full_q <= '0;
            stat_max_q  <= '0;
        end else begin
            if (offer_idle && req_legal && (stat_acc_q != '1)) begin
                stat_acc_q <= stat_acc_q + 32'd1;
            end
            if (offer_idle && !req_legal && (stat_drop_q != '1)) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
            if (full_wait && (stat_full_q != '1)) begin
                stat_full_q <= stat_full_q + 32'd1;
            end
            if (count > stat_max_q) begin
                stat_max_q <= count;
            end
        end
    end

    assign stat_accepted    = stat_acc_q;
    assign stat_dropped     = stat_drop_q;
    assign stat_full_cycles = stat_full_q;
    assign stat_max_count   = stat_max_q;
`endif
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed self-checking bench for mem_req_queue: reset, latency, time gating, backpressure, streaming, errors.
module tb_mem_req_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_time = '0;
    logic [3:0]  in_core = '0;
    logic [1:0]  in_op = '0;
    logic [35:0] in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_op;
    logic [3:0]  out_core;
    logic [35:0] out_addr;
    logic        out_channel;
    logic [2:0]  out_bg;
    logic [1:0]  out_bank;
    logic [5:0]  out_col;
    logic [15:0] out_row;
    logic [63:0] now_t;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        err_bounds;
`ifdef MEM_REQ_STATS_EN
    logic [31:0] stat_accepted, stat_dropped, stat_full_cycles;
    logic [4:0]  stat_max_count;
`endif

    int total = 0;
    int bad = 0;
    logic [63:0] tb_cyc;

    always #5 clk = ~clk;

    // Independent cycle reference: counts edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    mem_req_queue #(.DEPTH(16), .TIME_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_time     (in_time),
        .in_core     (in_core),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_core    (out_core),
        .out_addr    (out_addr),
        .out_channel (out_channel),
        .out_bg      (out_bg),
        .out_bank    (out_bank),
        .out_col     (out_col),
        .out_row     (out_row),
        .now_t       (now_t),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err_bounds  (err_bounds)
`ifdef MEM_REQ_STATS_EN
        ,
        .stat_accepted    (stat_accepted),
        .stat_dropped     (stat_dropped),
        .stat_full_cycles (stat_full_cycles),
        .stat_max_count   (stat_max_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one request once in_ready is seen, bounded by a cycle budget.
    task automatic send(input logic [63:0] t, input logic [3:0] c, input logic [1:0] o, input logic [35:0] a);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        in_valid = 1'b1; in_time = t; in_core = c; in_op = o; in_addr = a;
        tick();
        in_valid = 1'b0;
        $display("sent time=%0d core=%0d op=%0d addr=0x%09h", t, c, o, a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (count !== 5'd0)     begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full: got %0b want 0", full); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
        total++; if (err_bounds !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_bounds); end
        total++; if (now_t !== 64'd0)    begin bad++; $display("FAIL reset_now: got %0d want 0", now_t); end
        total++; if (out_addr !== 36'd0 || out_core !== 4'd0 || out_row !== 16'd0)
            begin bad++; $display("FAIL reset_out_fields: addr=0x%09h core=%0d row=%0d want all 0", out_addr, out_core, out_row); end
        rst_n = 1'b1;
        tick(); tick();
        total++; if (now_t !== 64'd2) begin bad++; $display("FAIL now_after_release: got %0d want 2", now_t); end
        $display("reset checked");
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_time = 64'd0; in_core = 4'd3; in_op = 2'd0; in_addr = 36'h0_0004_1C40;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_no_bypass: out_valid=%0b want 0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL lat_staged_ready: in_ready=%0b want 0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || count !== 5'd1)
            begin bad++; $display("FAIL lat_head: out_valid=%0b count=%0d want 1/1", out_valid, count); end
        total++; if ({out_channel, out_bg, out_bank, out_col, out_row} !== {1'b1, 3'd0, 2'd3, 6'd1, 16'd1})
            begin bad++; $display("FAIL lat_decode: ch=%0d bg=%0d bank=%0d col=%0d row=%0d want 1/0/3/1/1", out_channel, out_bg, out_bank, out_col, out_row); end
        total++; if (out_core !== 4'd3 || out_op !== 2'd0 || out_addr !== 36'h0_0004_1C40)
            begin bad++; $display("FAIL lat_fields: core=%0d op=%0d addr=0x%09h want 3/0/0x000041c40", out_core, out_op, out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (empty !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL lat_pop: empty=%0b out_valid=%0b in_ready=%0b want 1/0/1", empty, out_valid, in_ready); end
        $display("latency request popped");
    endtask

    task automatic test_future_time();
        logic [63:0] t;
        t = tb_cyc + 64'd6;
        in_valid = 1'b1; in_time = t; in_core = 4'd5; in_op = 2'd1; in_addr = 36'h1_2345_6789;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (out_valid !== (tb_cyc > t))
                begin bad++; $display("FAIL future_gate: cycle=%0d t=%0d out_valid=%0b want %0b", tb_cyc, t, out_valid, (tb_cyc > t)); end
            tick();
        end
        total++; if (out_core !== 4'd5 || out_op !== 2'd1 || out_addr !== 36'h1_2345_6789)
            begin bad++; $display("FAIL future_fields: core=%0d op=%0d addr=0x%09h", out_core, out_op, out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("future request released at time %0d", t);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(64'd0, 4'(i % 12), 2'(i % 3), 36'h100 + 36'(i));
        end
        total++; if (count !== 5'd16 || full !== 1'b1 || in_ready !== 1'b0)
            begin bad++; $display("FAIL bp_full: count=%0d full=%0b in_ready=%0b want 16/1/0", count, full, in_ready); end
        repeat (3) tick();
        total++; if (count !== 5'd16 || in_ready !== 1'b0 || out_addr !== 36'h100)
            begin bad++; $display("FAIL bp_hold: count=%0d in_ready=%0b addr=0x%09h want 16/0/0x100", count, in_ready, out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 5'd16 || full !== 1'b1 || in_ready !== 1'b1 || out_addr !== 36'h101)
            begin bad++; $display("FAIL bp_pop_push: count=%0d full=%0b in_ready=%0b addr=0x%09h want 16/1/1/0x101", count, full, in_ready, out_addr); end
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_addr !== 36'h100 + 36'(k))
                begin bad++; $display("FAIL bp_drain: k=%0d valid=%0b addr=0x%09h want 0x%09h", k, out_valid, out_addr, 36'h100 + 36'(k)); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1 || count !== 5'd0)
            begin bad++; $display("FAIL bp_empty: empty=%0b count=%0d want 1/0", empty, count); end
        $display("backpressure drained");
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        out_ready = 1'b1;
        while (got < 40 && cyc < 400) begin
            if (out_valid) begin
                total++;
                if (out_addr !== 36'h200 + 36'(got))
                    begin bad++; $display("FAIL stream_order: idx=%0d addr=0x%09h want 0x%09h", got, out_addr, 36'h200 + 36'(got)); end
                $display("pop idx=%0d addr=0x%09h", got, out_addr);
                got++;
            end
            if (in_ready && sent < 40) begin
                in_valid = 1'b1; in_time = 64'd0; in_core = 4'(sent % 12); in_op = 2'(sent % 3);
                in_addr = 36'h200 + 36'(sent);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (got != 40) begin bad++; $display("FAIL stream_count: got %0d pops want 40", got); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL stream_empty: empty=%0b want 1", empty); end
    endtask

    task automatic test_illegal();
        total++; if (err_bounds !== 1'b0) begin bad++; $display("FAIL ill_pre: err=%0b want 0", err_bounds); end
        in_valid = 1'b1; in_time = 64'd0; in_core = 4'd12; in_op = 2'd0; in_addr = 36'h0AB;
        tick();
        in_valid = 1'b0;
        total++; if (err_bounds !== 1'b1 || in_ready !== 1'b1 || count !== 5'd0)
            begin bad++; $display("FAIL ill_core: err=%0b in_ready=%0b count=%0d want 1/1/0", err_bounds, in_ready, count); end
        in_valid = 1'b1; in_core = 4'd0; in_op = 2'd3;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        total++; if (err_bounds !== 1'b1 || count !== 5'd0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL ill_op: err=%0b count=%0d out_valid=%0b want 1/0/0", err_bounds, count, out_valid); end
`ifdef MEM_REQ_STATS_EN
        total++; if (stat_dropped !== 32'd2) begin bad++; $display("FAIL stat_dropped: got %0d want 2", stat_dropped); end
        total++; if (stat_accepted !== 32'd59) begin bad++; $display("FAIL stat_accepted: got %0d want 59", stat_accepted); end
        total++; if (stat_max_count !== 5'd16) begin bad++; $display("FAIL stat_max: got %0d want 16", stat_max_count); end
`endif
        $display("illegal requests dropped");
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(64'd0, 4'd1, 2'd1, 36'h300 + 36'(i));
        end
        tick();
        total++; if (count !== 5'd9) begin bad++; $display("FAIL mid_fill: count=%0d want 9", count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (count !== 5'd0 || empty !== 1'b1 || now_t !== 64'd0)
            begin bad++; $display("FAIL mid_reset: count=%0d empty=%0b now=%0d want 0/1/0", count, empty, now_t); end
        total++; if (err_bounds !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL mid_reset_flags: err=%0b out_valid=%0b in_ready=%0b want 0/0/1", err_bounds, out_valid, in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (now_t !== 64'd1) begin bad++; $display("FAIL mid_now: got %0d want 1", now_t); end
        $display("mid-stream reset applied");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_future_time();
        test_backpressure();
        test_stream();
        test_illegal();
        test_midreset();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
